// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer with CDB capture, operand lookup and in-order commit
// A mispredicted branch at the head commits and flushes the whole buffer on the same edge.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_IDX_W = 4,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 issue_valid,
  input  logic [1:0]           issue_type,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_pred_taken,
  input  logic [XLEN-1:0]      issue_alt_pc,
  output logic [ROB_IDX_W-1:0] issue_tag,
  output logic                 full,
  output logic                 empty,
  input  logic                 wb_valid,
  input  logic [ROB_IDX_W-1:0] wb_tag,
  input  logic [XLEN-1:0]      wb_value,
  input  logic                 wb_taken,
  input  logic [ROB_IDX_W-1:0] q1_tag,
  input  logic [ROB_IDX_W-1:0] q2_tag,
  output logic                 q1_ready,
  output logic                 q2_ready,
  output logic [XLEN-1:0]      q1_value,
  output logic [XLEN-1:0]      q2_value,
  output logic                 commit_valid,
  output logic [ROB_IDX_W-1:0] commit_tag,
  output logic [4:0]           commit_rd,
  output logic [XLEN-1:0]      commit_value,
  output logic                 commit_is_store,
  output logic                 flush,
  output logic [XLEN-1:0]      flush_pc
);

  localparam logic [1:0] TYPE_REG    = 2'd0;
  localparam logic [1:0] TYPE_STORE  = 2'd1;
  localparam logic [1:0] TYPE_BRANCH = 2'd2;
  localparam logic [ROB_IDX_W:0] DEPTH_CNT = (ROB_IDX_W+1)'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0] busy_q, busy_d;
  logic [ROB_DEPTH-1:0] ready_q, pred_q, taken_q;
  logic [1:0]           type_q  [ROB_DEPTH];
  logic [4:0]           rd_q    [ROB_DEPTH];
  logic [XLEN-1:0]      value_q [ROB_DEPTH];
  logic [XLEN-1:0]      alt_q   [ROB_DEPTH];

  logic [ROB_IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_IDX_W:0]   count_q, count_d;

  logic                 commit_valid_q, commit_valid_d;
  logic [ROB_IDX_W-1:0] commit_tag_q, commit_tag_d;
  logic [4:0]           commit_rd_q, commit_rd_d;
  logic [XLEN-1:0]      commit_value_q, commit_value_d;
  logic                 commit_is_store_q, commit_is_store_d;
  logic                 flush_q, flush_d;
  logic [XLEN-1:0]      flush_pc_q, flush_pc_d;

  logic commit_fire, mispredict, issue_fire, wb_fire;
  logic wb_hit1, wb_hit2;

  // Commit looks only at registered state, so a same-cycle writeback to the head waits a cycle.
  assign commit_fire = busy_q[head_q] && ready_q[head_q];
  assign mispredict  = commit_fire && (type_q[head_q] == TYPE_BRANCH) &&
                       (taken_q[head_q] != pred_q[head_q]);
  assign full        = (count_q == DEPTH_CNT);
  assign empty       = (count_q == '0);
  assign issue_fire  = issue_valid && !full && !mispredict;
  assign wb_fire     = wb_valid && busy_q[wb_tag] && !mispredict;
  assign issue_tag   = tail_q;

  always_comb begin
    busy_d            = busy_q;
    head_d            = head_q;
    tail_d            = tail_q;
    count_d           = count_q;
    commit_valid_d    = commit_fire;
    commit_tag_d      = commit_fire ? head_q : '0;
    commit_rd_d       = (commit_fire && type_q[head_q] == TYPE_REG) ? rd_q[head_q] : '0;
    commit_value_d    = commit_fire ? value_q[head_q] : '0;
    commit_is_store_d = commit_fire && (type_q[head_q] == TYPE_STORE);
    flush_d           = mispredict;
    flush_pc_d        = mispredict ? alt_q[head_q] : '0;
    if (mispredict) begin
      busy_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue_fire) begin
        busy_d[tail_q] = 1'b1;
        tail_d         = tail_q + ROB_IDX_W'(1);
      end
      if (commit_fire) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + ROB_IDX_W'(1);
      end
      case ({issue_fire, commit_fire})
        2'b10:   count_d = count_q + (ROB_IDX_W+1)'(1);
        2'b01:   count_d = count_q - (ROB_IDX_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q            <= '0;
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      commit_valid_q    <= 1'b0;
      commit_tag_q      <= '0;
      commit_rd_q       <= '0;
      commit_value_q    <= '0;
      commit_is_store_q <= 1'b0;
      flush_q           <= 1'b0;
      flush_pc_q        <= '0;
    end else if (rdy) begin
      busy_q            <= busy_d;
      head_q            <= head_d;
      tail_q            <= tail_d;
      count_q           <= count_d;
      commit_valid_q    <= commit_valid_d;
      commit_tag_q      <= commit_tag_d;
      commit_rd_q       <= commit_rd_d;
      commit_value_q    <= commit_value_d;
      commit_is_store_q <= commit_is_store_d;
      flush_q           <= flush_d;
      flush_pc_q        <= flush_pc_d;
    end
  end

  // Payload needs no reset: every field is rewritten at allocation and gated by busy.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (issue_fire) begin
        ready_q[tail_q] <= 1'b0;
        taken_q[tail_q] <= 1'b0;
        pred_q[tail_q]  <= issue_pred_taken;
        type_q[tail_q]  <= (issue_type == 2'd3) ? TYPE_REG : issue_type;
        rd_q[tail_q]    <= issue_rd;
        alt_q[tail_q]   <= issue_alt_pc;
        value_q[tail_q] <= '0;
      end
      if (wb_fire) begin
        ready_q[wb_tag] <= 1'b1;
        taken_q[wb_tag] <= wb_taken;
        value_q[wb_tag] <= wb_value;
      end
    end
  end

  assign wb_hit1  = wb_valid && (wb_tag == q1_tag);
  assign wb_hit2  = wb_valid && (wb_tag == q2_tag);
  assign q1_ready = busy_q[q1_tag] && (ready_q[q1_tag] || wb_hit1);
  assign q2_ready = busy_q[q2_tag] && (ready_q[q2_tag] || wb_hit2);
  assign q1_value = !busy_q[q1_tag] ? '0 : (wb_hit1 ? wb_value : value_q[q1_tag]);
  assign q2_value = !busy_q[q2_tag] ? '0 : (wb_hit2 ? wb_value : value_q[q2_tag]);

  assign commit_valid    = commit_valid_q;
  assign commit_tag      = commit_tag_q;
  assign commit_rd       = commit_rd_q;
  assign commit_value    = commit_value_q;
  assign commit_is_store = commit_is_store_q;
  assign flush           = flush_q;
  assign flush_pc        = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed and random checks of reorder_buffer against a queue model
// The model keeps live instructions in program order in a queue; tags come from a modulo-16 counter.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, issue_valid, issue_pred_taken;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_alt_pc;
  logic [3:0]  issue_tag;
  logic        full, empty;
  logic        wb_valid, wb_taken;
  logic [3:0]  wb_tag;
  logic [31:0] wb_value;
  logic [3:0]  q1_tag, q2_tag;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic        commit_valid, commit_is_store, flush;
  logic [3:0]  commit_tag;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, flush_pc;

  reorder_buffer #(.ROB_DEPTH(16), .ROB_IDX_W(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .issue_tag(issue_tag), .full(full), .empty(empty),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_taken(wb_taken),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_is_store(commit_is_store),
    .flush(flush), .flush_pc(flush_pc)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic        pt;
    logic [31:0] alt;
    logic        done;
    logic [31:0] val;
    logic        tk;
  } ent_t;

  ent_t        rob[$];
  int          m_tail;
  logic        e_cv, e_cst, e_fl;
  logic [3:0]  e_ctag;
  logic [4:0]  e_crd;
  logic [31:0] e_cval, e_fpc;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_query(input logic [3:0] t, output logic r, output logic [31:0] v,
                             output logic f);
    f = 1'b0; r = 1'b0; v = '0;
    foreach (rob[i]) begin
      if (rob[i].tag == t) begin
        f = 1'b1;
        if (wb_valid && wb_tag == t) begin r = 1'b1; v = wb_value; end
        else begin r = rob[i].done; v = rob[i].val; end
      end
    end
  endtask

  task automatic model_update();
    logic cfire, mis, was_full;
    ent_t e;
    if (rst) begin
      rob.delete(); m_tail = 0;
      e_cv = 0; e_ctag = 0; e_crd = 0; e_cval = 0; e_cst = 0; e_fl = 0; e_fpc = 0;
    end else if (rdy) begin
      cfire    = (rob.size() > 0) && rob[0].done;
      mis      = cfire && rob[0].typ == 2'd2 && rob[0].tk != rob[0].pt;
      was_full = (rob.size() == 16);
      e_cv = cfire; e_ctag = 0; e_crd = 0; e_cval = 0; e_cst = 0;
      if (cfire) begin
        e_ctag = rob[0].tag;
        e_crd  = (rob[0].typ == 2'd0) ? rob[0].rd : 5'd0;
        e_cval = rob[0].val;
        e_cst  = (rob[0].typ == 2'd1);
        void'(rob.pop_front());
      end
      e_fl  = mis;
      e_fpc = mis ? e_fpc_src() : 32'd0;
      if (!mis && wb_valid)
        foreach (rob[i])
          if (rob[i].tag == wb_tag) begin
            rob[i].done = 1'b1; rob[i].val = wb_value; rob[i].tk = wb_taken;
          end
      if (!mis && issue_valid && !was_full) begin
        e.tag = 4'(m_tail); e.typ = (issue_type == 2'd3) ? 2'd0 : issue_type;
        e.rd = issue_rd; e.pt = issue_pred_taken; e.alt = issue_alt_pc;
        e.done = 1'b0; e.val = 0; e.tk = 1'b0;
        rob.push_back(e);
        m_tail = (m_tail + 1) % 16;
      end
      if (mis) begin rob.delete(); m_tail = 0; end
    end
  endtask

  // Redirect target of the branch being committed, captured before the queue is popped.
  logic [31:0] head_alt;
  function automatic logic [31:0] e_fpc_src();
    return head_alt;
  endfunction

  task automatic step();
    logic r, f;
    logic [31:0] v;
    @(negedge clk);
    model_query(q1_tag, r, v, f);
    check("q1_ready", q1_ready, r);
    if (!f || r) check("q1_value", q1_value, v);
    model_query(q2_tag, r, v, f);
    check("q2_ready", q2_ready, r);
    if (!f || r) check("q2_value", q2_value, v);
    head_alt = (rob.size() > 0) ? rob[0].alt : 32'd0;
    model_update();
    @(posedge clk); #1;
    check("commit_valid", commit_valid, e_cv);
    check("commit_tag", commit_tag, e_ctag);
    check("commit_rd", commit_rd, e_crd);
    check("commit_value", commit_value, e_cval);
    check("commit_is_store", commit_is_store, e_cst);
    check("flush", flush, e_fl);
    check("flush_pc", flush_pc, e_fpc);
    check("full", full, rob.size() == 16);
    check("empty", empty, rob.size() == 0);
    check("issue_tag", issue_tag, m_tail);
  endtask

  task automatic idle_inputs();
    rst = 0; rdy = 1; issue_valid = 0; issue_type = 0; issue_rd = 0;
    issue_pred_taken = 0; issue_alt_pc = 0; wb_valid = 0; wb_tag = 0;
    wb_value = 0; wb_taken = 0; q1_tag = 0; q2_tag = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; step(); rst = 0;
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [4:0] rd, input logic pt,
                          input logic [31:0] alt);
    issue_valid = 1; issue_type = t; issue_rd = rd; issue_pred_taken = pt; issue_alt_pc = alt;
    step();
    issue_valid = 0;
  endtask

  task automatic do_wb(input logic [3:0] t, input logic [31:0] v, input logic tk);
    wb_valid = 1; wb_tag = t; wb_value = v; wb_taken = tk;
    step();
    wb_valid = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    rob.delete(); m_tail = 0; head_alt = 0;
    e_cv = 0; e_ctag = 0; e_crd = 0; e_cval = 0; e_cst = 0; e_fl = 0; e_fpc = 0;
    do_reset();
    check("reset_empty", empty, 1);
    check("reset_commit_valid", commit_valid, 0);

    // single instruction round trip
    do_issue(2'd0, 5'd5, 1'b0, 32'd0);
    do_wb(4'd0, 32'h1234, 1'b0);
    step();
    check("t1_cv", commit_valid, 1);
    check("t1_rd", commit_rd, 5);
    check("t1_val", commit_value, 32'h1234);
    check("t1_tag", commit_tag, 0);
    check("t1_empty", empty, 1);
    step();
    check("t1_single_pulse", commit_valid, 0);

    // fill, overflow drop, reverse completion, in-order drain
    do_reset();
    for (int i = 0; i < 16; i++) do_issue(2'd0, 5'(i + 1), 1'b0, 32'd0);
    check("t2_full", full, 1);
    do_issue(2'd0, 5'd31, 1'b0, 32'd0);
    check("t2_drop_tag", issue_tag, 0);
    for (int i = 15; i >= 0; i--) begin
      do_wb(4'(i), 32'(i * 3 + 100), 1'b0);
      if (i > 0) check("t2_no_commit", commit_valid, 0);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      check("t2_cv", commit_valid, 1);
      check("t2_order", commit_tag, i);
      check("t2_val", commit_value, i * 3 + 100);
    end
    check("t2_empty", empty, 1);

    // out-of-order completion
    do_reset();
    for (int i = 0; i < 3; i++) do_issue(2'd0, 5'(i + 10), 1'b0, 32'd0);
    do_wb(4'd2, 32'hC2, 1'b0);
    do_wb(4'd1, 32'hC1, 1'b0);
    step();
    check("t3_wait", commit_valid, 0);
    do_wb(4'd0, 32'hC0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_order", commit_tag, i);
      check("t3_cv", commit_valid, 1);
    end

    // mispredicted branch flushes younger work
    do_reset();
    do_issue(2'd0, 5'd7, 1'b0, 32'd0);
    do_issue(2'd2, 5'd9, 1'b0, 32'h80);
    do_issue(2'd0, 5'd8, 1'b0, 32'd0);
    do_wb(4'd1, 32'h0, 1'b1);
    do_wb(4'd2, 32'h22, 1'b0);
    do_wb(4'd0, 32'h11, 1'b0);
    step();
    check("t4_first", commit_tag, 0);
    check("t4_no_flush_yet", flush, 0);
    step();
    check("t4_br_cv", commit_valid, 1);
    check("t4_br_tag", commit_tag, 1);
    check("t4_flush", flush, 1);
    check("t4_flush_pc", flush_pc, 32'h80);
    check("t4_br_rd", commit_rd, 0);
    check("t4_empty", empty, 1);
    check("t4_tail", issue_tag, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_tag2_dead", commit_valid, 0);
    end

    // query bypass
    do_reset();
    for (int i = 0; i < 4; i++) do_issue(2'd1, 5'd3, 1'b0, 32'd0);
    q1_tag = 4'd3; q2_tag = 4'd5;
    #1;
    check("t5_q1_not_ready", q1_ready, 0);
    wb_valid = 1; wb_tag = 4'd3; wb_value = 32'hAA;
    #1;
    check("t5_q1_bypass_ready", q1_ready, 1);
    check("t5_q1_bypass_value", q1_value, 32'hAA);
    check("t5_q2_idle", q2_ready, 0);
    check("t5_q2_idle_val", q2_value, 0);
    step();
    wb_valid = 0;
    step();

    // continuous stream with wrap, a 3-cycle freeze and a mid-stream reset
    do_reset();
    for (int i = 0; i < 26; i++) begin
      issue_valid = 1; issue_type = 2'd0; issue_rd = 5'(i % 31 + 1);
      wb_valid = (rob.size() > 0); wb_tag = 4'((m_tail + 15) % 16);
      wb_value = $urandom; wb_taken = 0;
      q1_tag = 4'((m_tail + 15) % 16); q2_tag = 4'($urandom_range(0, 15));
      rdy = !(i >= 10 && i < 13);
      step();
    end
    idle_inputs();
    rst = 1;
    step();
    check("t6_rst_cv", commit_valid, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_tag", issue_tag, 0);
    check("t6_rst_val", commit_value, 0);
    rst = 0;

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      int k;
      rst = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      issue_valid = ($urandom_range(0, 9) < 6);
      k = $urandom_range(0, 9);
      issue_type = (k < 6) ? 2'd0 : (k < 8) ? 2'd1 : (k == 8) ? 2'd2 : 2'd3;
      issue_rd = 5'($urandom); issue_pred_taken = 1'($urandom);
      issue_alt_pc = $urandom;
      wb_valid = ($urandom_range(0, 9) < 7);
      if (rob.size() > 0 && $urandom_range(0, 3) != 0)
        wb_tag = rob[$urandom_range(0, rob.size() - 1)].tag;
      else
        wb_tag = 4'($urandom);
      wb_value = $urandom; wb_taken = 1'($urandom);
      if (rob.size() > 0 && $urandom_range(0, 1) == 1)
        q1_tag = rob[$urandom_range(0, rob.size() - 1)].tag;
      else
        q1_tag = 4'($urandom);
      q2_tag = ($urandom_range(0, 1) == 1) ? wb_tag : 4'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
